// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - BRAM port-B burst reader with credit-checked skid FIFO onto a valid/ready stream
module bram_stream_reader #(
  parameter int WIDTH  = 272,
  parameter int AW     = 8,
  parameter int RD_LAT = 2,
  parameter int FDEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             ram_enb,
  output logic [AW-1:0]    ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + RD_LAT + 1) + 1;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       issued_q, issued_d;
  logic [AW:0]       popped_q, popped_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]  mem_q [FDEPTH];
  logic [WIDTH-1:0]  mem_d [FDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;

  logic              push, pop, enb, credit_ok;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     committed;

  // Reads outstanding in the BRAM pipeline, counting the one landing this cycle
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
  end

  // Credit check: a new read is allowed only if it still fits once this cycle's pop leaves
  always_comb begin
    pop       = (occ_q != '0) && m_ready;
    push      = tag_q[RD_LAT-1];
    committed = occ_q + inflight - CW'(pop);
    credit_ok = committed < CW'(FDEPTH);
    enb       = (state_q == ISSUE) && (issued_q != count_q) && credit_ok;
  end

  // Enable tag shift register mirrors the BRAM read latency
  always_comb begin
    tag_d    = '0;
    tag_d[0] = enb;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Burst sequencing: issue reads, wait for the last beat, then a one-cycle done pulse
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    base_d   = base_q;
    count_d  = count_q;
    issued_d = issued_q;
    popped_d = popped_q;
    if (pop) begin
      popped_d = popped_q + ONE;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = count;
          issued_d = '0;
          popped_d = '0;
          state_d  = (count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (enb) begin
          issued_d = issued_q + ONE;
          if ((issued_q + ONE) == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && ((popped_q + ONE) == count_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // An empty burst arrives here with done low and spends one extra cycle before pulsing
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Skid FIFO: push from the read pipeline, pop on stream handshake
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = ram_doutb;
      wr_ptr_d = (wr_ptr_q == PW'(FDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state, counters, read pipeline and FIFO pointers; all cleared by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      popped_q <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      assert (!(push && !pop && (occ_q == CW'(FDEPTH))));
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      base_q   <= base_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // FIFO storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_enb   = enb;
  assign ram_addrb = base_q + issued_q[AW-1:0];
  assign m_valid   = (occ_q != '0);
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last    = m_valid && (popped_q == (count_q - ONE));

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

  localparam int WIDTH  = 272;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;
  localparam int FDEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      count = '0;
  logic             busy, done, ram_enb;
  logic [AW-1:0]    ram_addrb;
  logic [WIDTH-1:0] ram_doutb, m_data;
  logic             m_valid, m_last;
  logic             m_ready = 1'b0;

  bram_stream_reader #(
    .WIDTH(WIDTH), .AW(AW), .RD_LAT(RD_LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with RD_LAT-cycle read latency; invalid slots read as all ones
  logic [WIDTH-1:0] ram_mem [256];
  logic [AW-1:0]    apipe [RD_LAT];
  logic             vpipe [RD_LAT];
  always @(posedge clk) begin
    vpipe[0] <= ram_enb;
    apipe[0] <= ram_addrb;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      apipe[i] <= apipe[i-1];
    end
  end
  assign ram_doutb = (vpipe[RD_LAT-1] === 1'b1) ? ram_mem[apipe[RD_LAT-1]] : {WIDTH{1'b1}};

  // Observation on the falling edge
  logic [WIDTH-1:0] data_q [$];
  logic             last_q [$];
  int               bcyc_q [$];
  logic [AW-1:0]    addr_q [$];
  int enb_total, pop_total, valid_cnt, done_cnt, done_cyc, max_out, stall_err;
  logic             stall_pending;
  logic [WIDTH-1:0] stall_data;

  always @(negedge clk) begin
    if (ram_enb) begin
      addr_q.push_back(ram_addrb);
      enb_total++;
    end
    if (m_valid) valid_cnt++;
    if (m_valid && m_ready) begin
      data_q.push_back(m_data);
      last_q.push_back(m_last);
      bcyc_q.push_back(cyc);
      pop_total++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((enb_total - pop_total) > max_out) max_out = enb_total - pop_total;
    if (stall_pending && (!m_valid || (m_data !== stall_data))) stall_err++;
    stall_pending = m_valid && !m_ready;
    stall_data    = m_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    data_q.delete();
    last_q.delete();
    bcyc_q.delete();
    addr_q.delete();
    enb_total = 0; pop_total = 0; valid_cnt = 0; done_cnt = 0;
    done_cyc = -1; max_out = 0; stall_err = 0; stall_pending = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] c, output int s);
    @(posedge clk); #1;
    base_addr = b;
    count     = c;
    start     = 1'b1;
    s         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit random_ready, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (random_ready) m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    int errs;
    int n;
    logic [WIDTH-1:0] exp_d;

    for (int i = 0; i < 256; i++) ram_mem[i] = WIDTH'(i * 3);
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", ram_enb, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // 1: base 0x10, count 4, ready held high
    m_ready = 1'b1;
    clear_mon();
    pulse_start(8'h10, 9'd4, s);
    wait_done(1'b0, 200);
    chk("t1_beats", data_q.size(), 4);
    chk("t1_d0", data_q[0], 'h30);
    chk("t1_d1", data_q[1], 'h33);
    chk("t1_d2", data_q[2], 'h36);
    chk("t1_d3", data_q[3], 'h39);
    chk("t1_last", {last_q[0], last_q[1], last_q[2], last_q[3]}, 4'b0001);
    chk("t1_addrs", {addr_q[0], addr_q[1], addr_q[2], addr_q[3]}, 32'h10111213);
    chk("t1_first_cyc", bcyc_q[0], s + 2 + RD_LAT);
    chk("t1_last_cyc", bcyc_q[3], s + 5 + RD_LAT);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, s + 6 + RD_LAT);

    // 2: count 0 gives a done pulse two cycles after start and nothing else
    clear_mon();
    pulse_start(8'h00, 9'd0, s);
    chk("t2_busy_c1", busy, 1);
    chk("t2_done_c1", done, 0);
    @(posedge clk); #1;
    chk("t2_busy_c2", busy, 1);
    chk("t2_done_c2", done, 1);
    @(posedge clk); #1;
    chk("t2_busy_c3", busy, 0);
    chk("t2_done_c3", done, 0);
    chk("t2_no_enb", enb_total, 0);
    chk("t2_no_valid", valid_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: address wrap FE, FF, 00, 01
    clear_mon();
    pulse_start(8'hFE, 9'd4, s);
    wait_done(1'b0, 200);
    chk("t3_addrs", {addr_q[0], addr_q[1], addr_q[2], addr_q[3]}, 32'hFEFF0001);
    chk("t3_d0", data_q[0], 'h2FA);
    chk("t3_d1", data_q[1], 'h2FD);
    chk("t3_d2", data_q[2], 'h0);
    chk("t3_d3", data_q[3], 'h3);

    // 4: 16 words with random backpressure
    clear_mon();
    pulse_start(8'h20, 9'd16, s);
    wait_done(1'b1, 2000);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      exp_d = WIDTH'((32 + i) * 3);
      if (data_q[i] !== exp_d || last_q[i] !== (i == 15)) errs++;
    end
    chk("t4_beats", data_q.size(), 16);
    chk("t4_content", errs, 0);
    chk("t4_stall_stable", stall_err, 0);
    chk("t4_credit", (max_out <= FDEPTH), 1);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: reset after 5 of 10 words, then a fresh 2-word burst
    clear_mon();
    pulse_start(8'h50, 9'd10, s);
    n = 0;
    while (data_q.size() < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_pre_beats", data_q.size(), 5);
    rstn = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_enb", ram_enb, 0);
    chk("t5_rst_data", m_data, 0);
    chk("t5_rst_addr", ram_addrb, 0);
    chk("t5_no_done", done_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("t5_quiet", valid_cnt + done_cnt + enb_total, 0);
    pulse_start(8'h00, 9'd2, s);
    wait_done(1'b0, 200);
    chk("t5_beats", data_q.size(), 2);
    chk("t5_d0", data_q[0], 'h0);
    chk("t5_d1", data_q[1], 'h3);
    chk("t5_last", {last_q[0], last_q[1]}, 2'b01);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: full 256-word sweep starting mid-RAM
    clear_mon();
    pulse_start(8'h80, 9'h100, s);
    wait_done(1'b0, 2000);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      exp_d = WIDTH'(((128 + i) % 256) * 3);
      if (data_q[i] !== exp_d || addr_q[i] !== AW'((128 + i) % 256) || last_q[i] !== (i == 255)) errs++;
    end
    chk("t6_beats", data_q.size(), 256);
    chk("t6_reads", addr_q.size(), 256);
    chk("t6_content", errs, 0);
    chk("t6_credit", (max_out <= FDEPTH), 1);
    chk("t6_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
